// File: rtl/serial_sub8_pkg.sv
// Shared constants for the bit-serial subtractor: controller state encoding and default width.
package serial_sub8_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub8_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface serial_sub8_if #(
  parameter int unsigned WIDTH = serial_sub8_pkg::DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, d, bout, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, d, bout, zero
  );

endinterface

// File: rtl/serial_sub8_sub1bit.sv
// One-bit full-subtractor cell; port order mirrors the ripple adder cell (borrow out first).
module sub1bit (
  output logic bo_o,
  output logic d_o,
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i
);

  always_comb begin
    d_o  = a_i ^ b_i ^ bin_i;
    bo_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
  end

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock with the borrow held in a flop.
module serial_sub8
  import serial_sub8_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          rst,
  serial_sub8_if.slave bus
);

  localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              borrow_q, borrow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic              bout_q, bout_d;
  logic              zero_q, zero_d;

  logic              cell_d;
  logic              cell_bo;
  logic [WIDTH-1:0]  r_next;

  sub1bit u_cell (
    .bo_o  (cell_bo),
    .d_o   (cell_d),
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .bin_i (borrow_q)
  );

  // New difference bit enters at the MSB so the LSB-first result lands in place after WIDTH shifts.
  assign r_next = {cell_d, r_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    bout_d   = bout_q;
    zero_d   = zero_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          r_d      = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        r_d      = r_next;
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = cell_bo;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          d_d     = r_next;
          bout_d  = cell_bo;
          zero_d  = (r_next == '0);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.d    = d_q;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_serial_sub8.sv
// Self-checking bench for serial_sub8: directed vectors, random operands, abort and streaming cases.
module tb_serial_sub8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_sub8_if #(.WIDTH(8)) bus ();

  serial_sub8 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_n  = 0;
  int check_n = 0;

  // Observations gathered by do_op for one transaction.
  int         ob_busy, ob_done_at, ob_done_n;
  bit         ob_overlap, ob_moved;
  logic [7:0] ob_d;
  logic       ob_bout, ob_zero;

  // Reference model: plain unsigned arithmetic.
  logic [7:0] ex_d;
  logic       ex_bout, ex_zero;

  task automatic model(input logic [7:0] a, input logic [7:0] b);
    int diff;
    diff    = int'(a) - int'(b);
    ex_bout = (diff < 0);
    ex_d    = 8'((diff + 256) % 256);
    ex_zero = (ex_d == 8'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and watch 12 cycles after the accepting edge.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] pre;
    pre = bus.d;
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    tick();
    bus.start = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    ob_busy = 0; ob_done_at = 0; ob_done_n = 0; ob_overlap = 0; ob_moved = 0;
    ob_d = 'x; ob_bout = 'x; ob_zero = 'x;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (bus.busy === 1'b1) ob_busy++;
      if (bus.busy === 1'b1 && bus.done === 1'b1) ob_overlap = 1;
      if (bus.done === 1'b1) begin
        ob_done_n++;
        if (ob_done_at == 0) begin
          ob_done_at = cyc;
          ob_d = bus.d;
          ob_bout = bus.bout;
          ob_zero = bus.zero;
        end
      end else if (ob_done_at == 0 && bus.d !== pre) begin
        ob_moved = 1;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = 8'd0;
    bus.b = 8'd0;
    tick();
    tick();
    check_n++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_n++;
    check_n++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_n++;
    check_n++; if (bus.d !== 8'd0) $display("FAIL reset_d got %0d want 0", bus.d); else pass_n++;
    check_n++; if (bus.bout !== 1'b0) $display("FAIL reset_bout got %b want 0", bus.bout); else pass_n++;
    check_n++; if (bus.zero !== 1'b0) $display("FAIL reset_zero got %b want 0", bus.zero); else pass_n++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_vectors();
    logic [7:0] va [5] = '{8'd100, 8'd37, 8'd0, 8'd0, 8'd128};
    logic [7:0] vb [5] = '{8'd37, 8'd100, 8'd0, 8'd1, 8'd127};
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i]);
      model(va[i], vb[i]);
      check_n++; if (ob_busy != 8) $display("FAIL vec%0d_busy_len got %0d want 8", i, ob_busy); else pass_n++;
      check_n++; if (ob_done_at != 9 || ob_done_n != 1)
        $display("FAIL vec%0d_done got at=%0d n=%0d want at=9 n=1", i, ob_done_at, ob_done_n);
      else pass_n++;
      check_n++; if (ob_overlap || ob_moved)
        $display("FAIL vec%0d_hs got overlap=%0d early_d=%0d want 0/0", i, ob_overlap, ob_moved);
      else pass_n++;
      check_n++; if ({ob_d, ob_bout, ob_zero} !== {ex_d, ex_bout, ex_zero})
        $display("FAIL vec%0d_result %0d-%0d got d=%0d bout=%b zero=%b want d=%0d bout=%b zero=%b",
                 i, va[i], vb[i], ob_d, ob_bout, ob_zero, ex_d, ex_bout, ex_zero);
      else pass_n++;
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom);
      b = (i % 4 == 0) ? a : 8'($urandom);
      do_op(a, b);
      model(a, b);
      check_n++; if (ob_busy != 8 || ob_done_at != 9 || ob_done_n != 1 || ob_overlap || ob_moved)
        $display("FAIL rnd%0d_timing got busy=%0d at=%0d n=%0d ov=%0d early=%0d want 8/9/1/0/0",
                 i, ob_busy, ob_done_at, ob_done_n, ob_overlap, ob_moved);
      else pass_n++;
      check_n++; if ({ob_d, ob_bout, ob_zero} !== {ex_d, ex_bout, ex_zero})
        $display("FAIL rnd%0d_result %0d-%0d got d=%0d bout=%b zero=%b want d=%0d bout=%b zero=%b",
                 i, a, b, ob_d, ob_bout, ob_zero, ex_d, ex_bout, ex_zero);
      else pass_n++;
    end
  endtask

  task automatic test_start_during_run();
    int         dn;
    logic [7:0] dv;
    dn = 0;
    dv = 'x;
    bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd55;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd1;
    tick();
    bus.start = 1'b0; bus.a = 8'd77; bus.b = 8'd9;
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (bus.done === 1'b1) begin
        dn++;
        if (dn == 1) dv = bus.d;
      end
      tick();
    end
    check_n++; if (dn != 1) $display("FAIL run_start_done_count got %0d want 1", dn); else pass_n++;
    check_n++; if (dv !== 8'd145) $display("FAIL run_start_d got %0d want 145", dv); else pass_n++;
  endtask

  task automatic test_reset_mid_run();
    int dn;
    bus.start = 1'b1; bus.a = 8'd100; bus.b = 8'd37;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_n++; if ({bus.busy, bus.done, bus.d, bus.bout} !== 11'd0)
      $display("FAIL abort_outputs got busy=%b done=%b d=%0d bout=%b want all 0",
               bus.busy, bus.done, bus.d, bus.bout);
    else pass_n++;
    dn = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
      tick();
    end
    check_n++; if (dn != 0) $display("FAIL abort_no_done got %0d active cycles want 0", dn); else pass_n++;
    // Reset wins over start on the same edge.
    rst = 1'b1; bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd2;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    check_n++; if (bus.busy !== 1'b0) $display("FAIL rst_over_start got busy=%b want 0", bus.busy); else pass_n++;
    tick();
    do_op(8'd5, 8'd3);
    check_n++; if (ob_d !== 8'd2 || ob_done_at != 9)
      $display("FAIL abort_restart got d=%0d at=%0d want d=2 at=9", ob_d, ob_done_at);
    else pass_n++;
  endtask

  task automatic test_back_to_back();
    int q[$];
    int bad_val, overlap;
    bad_val = 0;
    overlap = 0;
    rst = 1'b1; bus.start = 1'b1; bus.a = 8'd255; bus.b = 8'd255;
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      tick();
      if (bus.busy === 1'b1 && bus.done === 1'b1) overlap++;
      if (bus.done === 1'b1) begin
        q.push_back(cyc);
        if (bus.d !== 8'd0 || bus.zero !== 1'b1 || bus.bout !== 1'b0) bad_val++;
      end
    end
    bus.start = 1'b0;
    check_n++; if (q.size() != 4) $display("FAIL b2b_count got %0d want 4", q.size()); else pass_n++;
    for (int i = 0; i < q.size(); i++) begin
      check_n++; if (q[i] != 8 + 10 * i)
        $display("FAIL b2b_pos%0d got %0d want %0d", i, q[i], 8 + 10 * i);
      else pass_n++;
    end
    check_n++; if (bad_val != 0) $display("FAIL b2b_result got %0d bad want 0", bad_val); else pass_n++;
    check_n++; if (overlap != 0) $display("FAIL b2b_overlap got %0d want 0", overlap); else pass_n++;
    for (int i = 0; i < 12; i++) tick();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_n, check_n);
    $finish;
  end

endmodule
